lock_access_ctrl: RTL



---
 rtl/lock_pkg.sv | 18 +
 rtl/lock_key_encoder.sv | 10 +
 rtl/lock_access_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared types, widths and keypad decode helper for the password lock.
package lock_pkg;
  localparam int DIGIT_W = 4;
  localparam int KEY_W = 10;
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, FAIL, OPEN, PROG, LOCKOUT} state_t;
  function automatic logic [DIGIT_W:0] onehot_to_digit(input logic [KEY_W-1:0] k);
    logic [DIGIT_W-1:0] d;
    int n;
    d = '0;
    n = 0;
    for (int i = 0; i < KEY_W; i++)
      if (k[i]) begin
        d = DIGIT_W'(i);
        n++;
      end
    return {n == 1, d};
  endfunction
endpackage

// File: rtl/lock_key_encoder.sv
// lock_key_encoder: combinational one-hot keypad to digit decode with a good-key flag.
module lock_key_encoder
  import lock_pkg::*;
(
  input  logic [KEY_W-1:0]   key_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               good
);
  assign {good, digit} = onehot_to_digit(key_in);
endmodule

// File: rtl/lock_access_ctrl.sv
// lock_access_ctrl: code entry, attempt counting, timed unlock/lockout and reprogramming.
module lock_access_ctrl
  import lock_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter int          MAX_TRIES      = 5,
  parameter int          UNLOCK_CYCLES  = 50_000_000,
  parameter int          LOCKOUT_CYCLES = 250_000_000,
  parameter int          ENTRY_TIMEOUT  = 500_000_000,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0000_2103
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  input  logic             prog_req,
  output logic             unlock,
  output logic             alarm,
  output logic             wrong,
  output logic             prog_done,
  output logic             prog_err,
  output logic [2:0]       tries_left,
  output logic [3:0]       digit_cnt,
  output logic [2:0]       state_dbg
);
  localparam int CW = CODE_LEN * DIGIT_W;
  localparam int TMAX0 = UNLOCK_CYCLES > LOCKOUT_CYCLES ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX = TMAX0 > ENTRY_TIMEOUT ? TMAX0 : ENTRY_TIMEOUT;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);
  state_t state_q, state_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic [CW-1:0] buf_q, buf_d, code_q, code_d;
  logic bad_q, bad_d, pdone_q, pdone_d, perr_q, perr_d;
  logic [2:0] tries_q, tries_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DIGIT_W-1:0] digit;
  logic good, last, expired;
  lock_key_encoder u_enc (.key_in(key_in), .digit(digit), .good(good));
  assign last = dcnt_q + 4'd1 == 4'(CODE_LEN);
  assign expired = tmr_q == '0;
  always_comb begin
    state_d = state_q;
    dcnt_d = dcnt_q;
    buf_d = buf_q;
    bad_d = bad_q;
    code_d = code_q;
    tries_d = tries_q;
    tmr_d = expired ? tmr_q : tmr_q - TW'(1);
    pdone_d = 1'b0;
    perr_d = 1'b0;
    case (state_q)
      IDLE: if (key_valid) begin
        buf_d[DIGIT_W-1:0] = digit;
        bad_d = !good;
        dcnt_d = 4'd1;
        tmr_d = T_ENTRY;
        state_d = CODE_LEN == 1 ? CHECK : ENTRY;
      end
      ENTRY: if (key_valid) begin
        buf_d[dcnt_q*DIGIT_W +: DIGIT_W] = digit;
        bad_d = bad_q | !good;
        dcnt_d = dcnt_q + 4'd1;
        tmr_d = T_ENTRY;
        state_d = last ? CHECK : ENTRY;
      end else if (expired) begin
        buf_d = '0;
        bad_d = 1'b0;
        dcnt_d = '0;
        state_d = IDLE;
      end
      CHECK: begin
        dcnt_d = '0;
        if (!bad_q && buf_q == code_q) begin
          tries_d = TRIES_MAX;
          tmr_d = T_UNLOCK;
          state_d = OPEN;
        end else begin
          tries_d = tries_q == 3'd0 ? 3'd0 : tries_q - 3'd1;
          tmr_d = T_LOCK;
          state_d = tries_q <= 3'd1 ? LOCKOUT : FAIL;
        end
      end
      FAIL: state_d = IDLE;
      OPEN: if (expired) state_d = IDLE;
      else if (prog_req) begin
        dcnt_d = '0;
        tmr_d = T_ENTRY;
        state_d = PROG;
      end
      PROG: if (key_valid && !good) begin
        perr_d = 1'b1;
        dcnt_d = '0;
        state_d = IDLE;
      end else if (key_valid) begin
        buf_d[dcnt_q*DIGIT_W +: DIGIT_W] = digit;
        dcnt_d = last ? 4'd0 : dcnt_q + 4'd1;
        tmr_d = T_ENTRY;
        code_d = last ? buf_d : code_q;
        pdone_d = last;
        state_d = last ? IDLE : PROG;
      end else if (expired) begin
        perr_d = 1'b1;
        dcnt_d = '0;
        state_d = IDLE;
      end
      LOCKOUT: begin
        tries_d = expired ? TRIES_MAX : 3'd0;
        state_d = expired ? IDLE : LOCKOUT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      dcnt_q <= '0;
      buf_q <= '0;
      bad_q <= 1'b0;
      code_q <= DEFAULT_CODE[CW-1:0];
      tries_q <= TRIES_MAX;
      tmr_q <= '0;
      pdone_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q <= dcnt_d;
      buf_q <= buf_d;
      bad_q <= bad_d;
      code_q <= code_d;
      tries_q <= tries_d;
      tmr_q <= tmr_d;
      pdone_q <= pdone_d;
      perr_q <= perr_d;
    end
  assign unlock = state_q == OPEN;
  assign alarm = state_q == LOCKOUT;
  assign wrong = state_q == FAIL;
  assign prog_done = pdone_q;
  assign prog_err = perr_q;
  assign tries_left = tries_q;
  assign digit_cnt = dcnt_q;
  assign state_dbg = state_q;
endmodule
